// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost collision detector: edge codes,
// the per-frame edge mask type and the invulnerability FSM states.
package ghost_pkg;

  localparam int EDGE_BOTTOM = 0;
  localparam int EDGE_LEFT   = 1;
  localparam int EDGE_RIGHT  = 2;
  localparam int EDGE_TOP    = 3;
  localparam int EDGE_CORNER = 4;

  typedef logic [4:0] edge_mask_t;

  typedef enum logic {
    ACTIVE   = 1'b0,
    COOLDOWN = 1'b1
  } ghost_state_e;

endpackage

// File: rtl/frame_cooldown_counter.sv
// Pac-Man/ghost contact FSM: emits one hit pulse, then holds the invulnerable
// flag for INVULN_FRAMES frame boundaries before accepting contacts again.
module frame_cooldown_counter
  import ghost_pkg::*;
#(
  parameter int INVULN_FRAMES = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic start_of_frame,
  input  logic contact,
  output logic hit_pulse,
  output logic invulnerable
);

  localparam int CNT_W = $clog2(INVULN_FRAMES + 1);
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(INVULN_FRAMES - 1);

  ghost_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACTIVE;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch forms.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    case (state_q)
      ACTIVE: begin
        if (contact) begin
          hit_d   = 1'b1;
          state_d = COOLDOWN;
          cnt_d   = '0;
        end
      end
      COOLDOWN: begin
        if (start_of_frame) begin
          if (cnt_q == LAST_FRAME) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  assign hit_pulse    = hit_q;
  assign invulnerable = (state_q == COOLDOWN);

endmodule

// File: rtl/ghost_collision_detector.sv
// Samples ghost/wall/Pac-Man draw requests during the scan, accumulates ghost
// edges touching walls per frame and reports them once per frame.
module ghost_collision_detector
  import ghost_pkg::*;
#(
  parameter int INVULN_FRAMES = 60,
  parameter int EDGE_CODES    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       enable,
  input  logic       ghostDrawingRequest,
  input  logic [2:0] ghostHitEdgeCode,
  input  logic       pacmanDrawingRequest,
  input  logic       wallDrawingRequest,
  output logic       ghostWallHit,
  output logic [4:0] ghostWallEdgeMask,
  output logic       pacmanGhostHit,
  output logic       invulnerable
);

  logic       gw, pg;
  edge_mask_t pixel_mask;
  edge_mask_t accum_q;
  edge_mask_t mask_q;
  logic       wall_hit_q;

  assign gw = enable & ghostDrawingRequest & wallDrawingRequest;
  assign pg = enable & ghostDrawingRequest & pacmanDrawingRequest;

  always_comb begin
    pixel_mask = '0;
    if (gw && (int'(ghostHitEdgeCode) < EDGE_CODES))
      pixel_mask = edge_mask_t'(1) << ghostHitEdgeCode;
  end

  // A wall pixel on the frame-start cycle belongs to the new frame, so it
  // seeds the accumulator instead of being lost to the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      accum_q    <= '0;
      mask_q     <= '0;
      wall_hit_q <= 1'b0;
    end else if (startOfFrame) begin
      mask_q     <= accum_q;
      wall_hit_q <= |accum_q;
      accum_q    <= pixel_mask;
    end else begin
      wall_hit_q <= 1'b0;
      accum_q    <= accum_q | pixel_mask;
    end
  end

  frame_cooldown_counter #(
    .INVULN_FRAMES(INVULN_FRAMES)
  ) u_cooldown (
    .clk           (clk),
    .reset         (reset),
    .start_of_frame(startOfFrame),
    .contact       (pg),
    .hit_pulse     (pacmanGhostHit),
    .invulnerable  (invulnerable)
  );

  assign ghostWallHit      = wall_hit_q;
  assign ghostWallEdgeMask = mask_q;

endmodule

// File: tb/tb_ghost_collision_detector.sv
// Directed bench for ghost_collision_detector with a 3-frame invulnerability
// window; expected values are hand-derived constants.
module tb_ghost_collision_detector;
  import ghost_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame;
  logic       enable;
  logic       ghostDrawingRequest;
  logic [2:0] ghostHitEdgeCode;
  logic       pacmanDrawingRequest;
  logic       wallDrawingRequest;
  logic       ghostWallHit;
  logic [4:0] ghostWallEdgeMask;
  logic       pacmanGhostHit;
  logic       invulnerable;

  int n_checks = 0;
  int n_errors = 0;
  int pulses;

  always #5 clk = ~clk;

  ghost_collision_detector #(
    .INVULN_FRAMES(3),
    .EDGE_CODES   (5)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .startOfFrame        (startOfFrame),
    .enable              (enable),
    .ghostDrawingRequest (ghostDrawingRequest),
    .ghostHitEdgeCode    (ghostHitEdgeCode),
    .pacmanDrawingRequest(pacmanDrawingRequest),
    .wallDrawingRequest  (wallDrawingRequest),
    .ghostWallHit        (ghostWallHit),
    .ghostWallEdgeMask   (ghostWallEdgeMask),
    .pacmanGhostHit      (pacmanGhostHit),
    .invulnerable        (invulnerable)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sof, input logic en, input logic gd,
                       input logic [2:0] code, input logic pd, input logic wd);
    startOfFrame         = sof;
    enable               = en;
    ghostDrawingRequest  = gd;
    ghostHitEdgeCode     = code;
    pacmanDrawingRequest = pd;
    wallDrawingRequest   = wd;
  endtask

  // Outputs are sampled 1 time unit after the edge that produced them.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 3'd0, 0, 0);
    tick();
    tick();
    check("rst_wall_hit", 8'(ghostWallHit), 8'd0);
    check("rst_mask", 8'(ghostWallEdgeMask), 8'd0);
    check("rst_pg_hit", 8'(pacmanGhostHit), 8'd0);
    check("rst_invuln", 8'(invulnerable), 8'd0);
    reset = 1'b0;

    // Edges 1 and 3 touch walls, reported after the next frame start.
    drive(0, 1, 1, 3'(EDGE_LEFT), 0, 1);  tick();
    check("no_report_mid_frame", 8'(ghostWallHit), 8'd0);
    drive(0, 1, 1, 3'(EDGE_TOP), 0, 1);   tick();
    drive(0, 1, 0, 3'd0, 0, 0);           tick();
    drive(1, 1, 0, 3'd0, 0, 0);           tick();
    check("t1_wall_hit", 8'(ghostWallHit), 8'd1);
    check("t1_mask", 8'(ghostWallEdgeMask), 8'b01010);
    drive(0, 1, 0, 3'd0, 0, 0);           tick();
    check("t1_hit_one_cycle", 8'(ghostWallHit), 8'd0);
    check("t1_mask_held", 8'(ghostWallEdgeMask), 8'b01010);
    tick();
    drive(1, 1, 0, 3'd0, 0, 0);           tick();
    check("t1_empty_hit", 8'(ghostWallHit), 8'd0);
    check("t1_empty_mask", 8'(ghostWallEdgeMask), 8'd0);

    // Overlap on the frame-start cycle belongs to the new frame.
    drive(0, 1, 1, 3'(EDGE_BOTTOM), 0, 1); tick();
    drive(1, 1, 1, 3'(EDGE_RIGHT), 0, 1);  tick();
    check("t2_wall_hit", 8'(ghostWallHit), 8'd1);
    check("t2_mask_old", 8'(ghostWallEdgeMask), 8'b00001);
    drive(0, 1, 0, 3'd0, 0, 0);            tick();
    drive(1, 1, 0, 3'd0, 0, 0);            tick();
    check("t2_wall_hit_next", 8'(ghostWallHit), 8'd1);
    check("t2_mask_new", 8'(ghostWallEdgeMask), 8'b00100);

    // Ten cycles of Pac-Man contact give exactly one pulse.
    drive(0, 1, 1, 3'd0, 1, 0);            tick();
    check("t3_first_pulse", 8'(pacmanGhostHit), 8'd1);
    check("t3_invuln", 8'(invulnerable), 8'd1);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      pulses += int'(pacmanGhostHit);
    end
    check("t3_extra_pulses", 8'(pulses), 8'd0);
    check("t3_invuln_held", 8'(invulnerable), 8'd1);

    // Contacts during three cooldown frames are suppressed.
    pulses = 0;
    for (int f = 0; f < 3; f++) begin
      drive(0, 1, 1, 3'd0, 1, 0);
      for (int i = 0; i < 3; i++) begin
        tick();
        pulses += int'(pacmanGhostHit);
      end
      drive(1, 1, 1, 3'd0, 1, 0);
      tick();
      pulses += int'(pacmanGhostHit);
      check($sformatf("t4_invuln_f%0d", f), 8'(invulnerable), (f < 2) ? 8'd1 : 8'd0);
    end
    check("t4_cooldown_pulses", 8'(pulses), 8'd0);
    drive(0, 1, 1, 3'd0, 1, 0);            tick();
    check("t4_new_pulse", 8'(pacmanGhostHit), 8'd1);
    check("t4_reinvuln", 8'(invulnerable), 8'd1);
    drive(0, 1, 0, 3'd0, 0, 0);            tick();
    check("t4_pulse_ends", 8'(pacmanGhostHit), 8'd0);

    // Out-of-range code alone reports nothing; mixed with corner, only bit 4.
    drive(0, 1, 1, 3'd6, 0, 1);            tick();
    drive(1, 1, 0, 3'd0, 0, 0);            tick();
    check("t5_code6_hit", 8'(ghostWallHit), 8'd0);
    check("t5_code6_mask", 8'(ghostWallEdgeMask), 8'd0);
    drive(0, 1, 1, 3'd6, 0, 1);            tick();
    drive(0, 1, 1, 3'(EDGE_CORNER), 0, 1); tick();
    drive(0, 1, 1, 3'd7, 0, 1);            tick();
    drive(0, 1, 1, 3'd5, 0, 1);            tick();
    drive(1, 1, 0, 3'd0, 0, 0);            tick();
    check("t5_corner_hit", 8'(ghostWallHit), 8'd1);
    check("t5_corner_mask", 8'(ghostWallEdgeMask), 8'b10000);

    // Reset mid-cooldown with a pending accumulator.
    drive(0, 1, 1, 3'(EDGE_LEFT), 0, 1);   tick();
    check("t6_pre_invuln", 8'(invulnerable), 8'd1);
    reset = 1'b1;
    drive(0, 1, 0, 3'd0, 0, 0);            tick();
    check("t6_rst_wall_hit", 8'(ghostWallHit), 8'd0);
    check("t6_rst_mask", 8'(ghostWallEdgeMask), 8'd0);
    check("t6_rst_pg_hit", 8'(pacmanGhostHit), 8'd0);
    check("t6_rst_invuln", 8'(invulnerable), 8'd0);
    reset = 1'b0;
    drive(1, 1, 0, 3'd0, 0, 0);            tick();
    check("t6_post_hit", 8'(ghostWallHit), 8'd0);
    check("t6_post_mask", 8'(ghostWallEdgeMask), 8'd0);

    // Disabled: overlaps ignored, frame reports still happen.
    pulses = 0;
    drive(0, 0, 1, 3'(EDGE_RIGHT), 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(pacmanGhostHit);
    end
    check("t7_no_pulse", 8'(pulses), 8'd0);
    check("t7_no_invuln", 8'(invulnerable), 8'd0);
    drive(1, 0, 1, 3'(EDGE_RIGHT), 1, 1);  tick();
    check("t7_hit", 8'(ghostWallHit), 8'd0);
    check("t7_mask", 8'(ghostWallEdgeMask), 8'd0);
    drive(0, 1, 1, 3'd0, 1, 0);            tick();
    check("t7_enabled_pulse", 8'(pacmanGhostHit), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
